// File: rtl/alarm_controller.sv
// Alarm decision logic: edge-triggered match against the alarm time, ring timeout
// and snooze interval on a shared 1 Hz tick counter, with registered outputs.
module alarm_controller #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int CNT_W      = $clog2((SNOOZE_MIN * 60 > RING_SECS) ? SNOOZE_MIN * 60 : RING_SECS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] TH1,
  input  logic [3:0] TH2,
  input  logic [2:0] TM1,
  input  logic [3:0] TM2,
  input  logic [1:0] AH1,
  input  logic [3:0] AH2,
  input  logic [2:0] AM1,
  input  logic [3:0] AM2,
  input  logic       alarm_en,
  input  logic       adjust,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       alarm_led,
  output logic       snoozing,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN * 60 - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2,
    S_BAD    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_match_q;
  logic             r_led;
  logic             w_led_nxt;
  logic             r_ringing;
  logic             r_snoozing;
  logic             w_match;
  logic             w_trigger;

  function automatic logic time_eq(
    input logic [1:0] h1, input logic [3:0] h2, input logic [2:0] m1, input logic [3:0] m2,
    input logic [1:0] a1, input logic [3:0] a2, input logic [2:0] b1, input logic [3:0] b2
  );
    return (h1 == a1) && (h2 == a2) && (m1 == b1) && (m2 == b2);
  endfunction

  // Next-state, counter and LED decode
  always_comb begin
    w_match     = time_eq(TH1, TH2, TM1, TM2, AH1, AH2, AM1, AM2);
    w_trigger   = w_match && !r_match_q && alarm_en && !adjust;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_led_nxt   = r_led;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = S_RING;
          w_cnt_nxt   = CNT_ZERO;
          w_led_nxt   = 1'b1;
        end else begin
          w_cnt_nxt   = CNT_ZERO;
          w_led_nxt   = 1'b0;
        end
      end
      S_RING: begin
        if (stop || !alarm_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          w_led_nxt   = 1'b0;
        end else if (snooze) begin
          w_state_nxt = S_SNOOZE;
          w_cnt_nxt   = CNT_ZERO;
          w_led_nxt   = 1'b0;
        end else if (tick) begin
          if (r_cnt == RING_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = CNT_ZERO;
            w_led_nxt   = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
            w_led_nxt   = ~r_led;
          end
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      S_SNOOZE: begin
        // snooze and trigger are deliberately not decoded here
        if (stop || !alarm_en) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
          w_led_nxt   = 1'b0;
        end else if (tick) begin
          if (r_cnt == SNOOZE_LAST) begin
            w_state_nxt = S_RING;
            w_cnt_nxt   = CNT_ZERO;
            w_led_nxt   = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_ONE;
          end
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_led_nxt   = 1'b0;
      end
    endcase
  end

  // State, counter, match history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= CNT_ZERO;
      r_match_q  <= 1'b1;  // suppresses a ring when reset lands inside the alarm minute
      r_led      <= 1'b0;
      r_ringing  <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_match_q  <= w_match;
      r_led      <= w_led_nxt;
      r_ringing  <= (w_state_nxt == S_RING);
      r_snoozing <= (w_state_nxt == S_SNOOZE);
    end
  end

  assign ringing   = r_ringing;
  assign alarm_led = r_led;
  assign snoozing  = r_snoozing;
  assign state     = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed self-checking bench for alarm_controller (default 60 s ring, 5 min snooze).
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] TH1 = 2'd0;
  logic [3:0] TH2 = 4'd7;
  logic [2:0] TM1 = 3'd3;
  logic [3:0] TM2 = 4'd0;
  logic [1:0] AH1 = 2'd0;
  logic [3:0] AH2 = 4'd7;
  logic [2:0] AM1 = 3'd3;
  logic [3:0] AM2 = 4'd0;
  logic       alarm_en = 1'b1;
  logic       adjust = 1'b0;
  logic       stop = 1'b0;
  logic       snooze = 1'b0;
  logic       ringing;
  logic       alarm_led;
  logic       snoozing;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clk(clk), .rst(rst), .tick(tick),
    .TH1(TH1), .TH2(TH2), .TM1(TM1), .TM2(TM2),
    .AH1(AH1), .AH2(AH2), .AM1(AM1), .AM2(AM2),
    .alarm_en(alarm_en), .adjust(adjust), .stop(stop), .snooze(snooze),
    .ringing(ringing), .alarm_led(alarm_led), .snoozing(snoozing), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_min(input logic [3:0] m2);
    TM2 = m2;
    if (m2 == 4'd9) TM1 = 3'd2; else TM1 = 3'd3;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  // 07:29 -> 07:30 edge, leaves the alarm ringing if enabled
  task automatic arm_edge();
    set_min(4'd9); step();
    set_min(4'd0); step();
  endtask

  initial begin
    // 1: reset inside the alarm minute must not ring
    step(); step();
    check("rst_state", {6'd0, state}, 8'd0);
    check("rst_ring", {7'd0, ringing}, 8'd0);
    check("rst_led", {7'd0, alarm_led}, 8'd0);
    check("rst_snz", {7'd0, snoozing}, 8'd0);
    rst = 1'b0;
    step(); step();
    check("no_ring_after_rst", {7'd0, ringing}, 8'd0);
    set_min(4'd1); step();
    set_min(4'd0); step();
    check("t1_ring", {7'd0, ringing}, 8'd1);
    check("t1_led", {7'd0, alarm_led}, 8'd1);
    check("t1_state", {6'd0, state}, 8'd1);

    // 2: LED toggles per tick, timeout after 60 ticks
    ticks(1);
    check("t2_led_tick1", {7'd0, alarm_led}, 8'd0);
    ticks(1);
    check("t2_led_tick2", {7'd0, alarm_led}, 8'd1);
    ticks(57);
    check("t2_state_59", {6'd0, state}, 8'd1);
    ticks(1);
    check("t2_timeout_state", {6'd0, state}, 8'd0);
    check("t2_timeout_ring", {7'd0, ringing}, 8'd0);
    step(); step();
    check("t2_no_retrigger", {6'd0, state}, 8'd0);

    // 3: snooze for 300 ticks then ring again, stop, no retrigger
    arm_edge();
    check("t3_ring", {7'd0, ringing}, 8'd1);
    snooze = 1'b1; step(); snooze = 1'b0;
    check("t3_snz_state", {6'd0, state}, 8'd2);
    check("t3_snz_out", {7'd0, snoozing}, 8'd1);
    check("t3_snz_ring", {7'd0, ringing}, 8'd0);
    snooze = 1'b1; step(); snooze = 1'b0;
    check("t3_snz_ignored", {6'd0, state}, 8'd2);
    ticks(299);
    check("t3_snz_299", {6'd0, state}, 8'd2);
    ticks(1);
    check("t3_rering_state", {6'd0, state}, 8'd1);
    check("t3_rering_ring", {7'd0, ringing}, 8'd1);
    check("t3_rering_led", {7'd0, alarm_led}, 8'd1);
    stop = 1'b1; step(); stop = 1'b0;
    check("t3_stop", {6'd0, state}, 8'd0);
    step(); step();
    check("t3_no_retrigger", {7'd0, ringing}, 8'd0);

    // 4: stop beats snooze; stop and snooze beat timeout
    arm_edge();
    stop = 1'b1; snooze = 1'b1; step(); stop = 1'b0; snooze = 1'b0;
    check("t4_stop_snz", {6'd0, state}, 8'd0);
    arm_edge();
    ticks(59);
    tick = 1'b1; stop = 1'b1; step(); tick = 1'b0; stop = 1'b0;
    check("t4_stop_timeout", {6'd0, state}, 8'd0);
    arm_edge();
    ticks(59);
    tick = 1'b1; snooze = 1'b1; step(); tick = 1'b0; snooze = 1'b0;
    check("t4_snz_timeout", {6'd0, state}, 8'd2);
    stop = 1'b1; step(); stop = 1'b0;
    check("t4_snz_stop", {6'd0, state}, 8'd0);

    // 5: adjust and alarm_en gating
    adjust = 1'b1;
    arm_edge();
    check("t5_adjust", {6'd0, state}, 8'd0);
    adjust = 1'b0;
    step();
    check("t5_adjust_release", {6'd0, state}, 8'd0);
    alarm_en = 1'b0;
    arm_edge();
    check("t5_disabled", {6'd0, state}, 8'd0);
    alarm_en = 1'b1;
    step();
    check("t5_enable_late", {6'd0, state}, 8'd0);
    arm_edge();
    adjust = 1'b1; step(); adjust = 1'b0;
    check("t5_adjust_ringing", {6'd0, state}, 8'd1);
    snooze = 1'b1; step(); snooze = 1'b0;
    alarm_en = 1'b0; step();
    check("t5_en_off_snz", {6'd0, state}, 8'd0);
    check("t5_en_off_snzout", {7'd0, snoozing}, 8'd0);
    alarm_en = 1'b1;

    // 6: reset mid-snooze
    arm_edge();
    snooze = 1'b1; step(); snooze = 1'b0;
    ticks(150);
    check("t6_snz_mid", {6'd0, state}, 8'd2);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rst_state", {6'd0, state}, 8'd0);
    check("t6_rst_outs", {5'd0, ringing, alarm_led, snoozing}, 8'd0);
    ticks(5);
    check("t6_no_ring", {7'd0, ringing}, 8'd0);
    check("t6_idle", {6'd0, state}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the clock top level's time digits and alarm digits.
- Decides when the alarm sounds, runs the ring timeout and snooze interval, and produces the ringing, LED-blink and status outputs.
- Runs on the system clock, with a one-cycle 1 Hz enable pulse (`tick`) as its time base.
- Sits beside the display mux and drives the buzzer/LED pins.

Parameters:
- RING_SECS, 60, ticks of ringing before automatic return to IDLE (≥1).
- SNOOZE_MIN, 5, snooze length in minutes; the snooze counter runs SNOOZE_MIN*60 ticks (≥1).
- CNT_W, $clog2(SNOOZE_MIN*60 > RING_SECS ? SNOOZE_MIN*60 : RING_SECS), shared tick counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- tick  input  1  1 Hz enable, high for exactly one clk cycle
- TH1  input  2  current time, hour tens digit
- TH2  input  4  current time, hour units digit
- TM1  input  3  current time, minute tens digit
- TM2  input  4  current time, minute units digit
- AH1  input  2  alarm hour tens digit
- AH2  input  4  alarm hour units digit
- AM1  input  3  alarm minute tens digit
- AM2  input  4  alarm minute units digit
- alarm_en  input  1  alarm armed switch (level)
- adjust  input  1  time-adjust mode active (level)
- stop  input  1  stop request, debounced single-cycle pulse
- snooze  input  1  snooze request, debounced single-cycle pulse
- ringing  output  1  high while in RINGING (buzzer drive)
- alarm_led  output  1  blinks at 0.5 Hz while ringing
- snoozing  output  1  high while in SNOOZE
- state  output  2  current state: 0 IDLE, 1 RINGING, 2 SNOOZE; 3 unused

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, counter=0, ringing=0, alarm_led=0, snoozing=0, match_q=1.
  - match_q resets to 1 so a reset taken during the alarm minute does not ring.
- Match: match = (TH1==AH1)&&(TH2==AH2)&&(TM1==AM1)&&(TM2==AM2), combinational.
  - match_q <= match every cycle.
  - Trigger = match && !match_q && alarm_en && !adjust.
  - Edge-based trigger: a stopped alarm does not retrigger within the same minute.
- All outputs are registered. ringing = (state==RINGING); snoozing = (state==SNOOZE).
- Latency: trigger in cycle k → ringing=1 in cycle k+1.
- IDLE:
  - On trigger → RINGING, counter=0, alarm_led=1.
  - tick is ignored.
- RINGING (priority top-down):
  1. stop or !alarm_en → IDLE, counter=0, alarm_led=0.
  2. snooze → SNOOZE, counter=0, alarm_led=0.
  3. tick with counter==RING_SECS-1 → IDLE (timeout), counter=0, alarm_led=0.
  4. tick otherwise → counter+1, alarm_led toggles.
  - A new trigger while RINGING is ignored.
  - adjust does not stop an active ring.
- SNOOZE (priority top-down):
  1. stop or !alarm_en → IDLE, counter=0.
  2. tick with counter==SNOOZE_MIN*60-1 → RINGING, counter=0, alarm_led=1.
  3. tick otherwise → counter+1.
  - snooze pulse is ignored. Trigger is ignored.
- Simultaneous events:
  - stop beats snooze.
  - stop or snooze beats timeout in the same cycle.
  - rst beats everything, mid-ring or mid-snooze.
- Counter: the one counter is shared by both states and cleared on every state change. It never exceeds its terminal value and never wraps.
- state 3 is unreachable; if entered, go to IDLE on the next clk.

Test Plan:
1. Reset with time 07:30, alarm 07:30, alarm_en=1 → ringing stays 0 (match_q reset to 1). Time steps 07:30→07:31→07:30 → ringing=1 one clk after the second 07:30 appears.
2. Time steps 07:29→07:30, alarm 07:30, alarm_en=1, adjust=0 → ringing=1 next clk, alarm_led=1. alarm_led toggles on each tick. After 60 ticks (RING_SECS=60) → state=0, ringing=0.
3. Ringing; snooze pulse → state=2, snoozing=1, ringing=0. After 300 ticks → state=1, ringing=1. Then stop pulse → state=0. Time unchanged at 07:30 → no retrigger.
4. Ringing; stop and snooze asserted in the same cycle → state=0. Also: stop on the same cycle as the 60th tick → state=0.
5. adjust=1 while time steps onto the alarm value → no ring. alarm_en=0 at the 07:29→07:30 step → no ring. Deassert alarm_en during SNOOZE → state=0 next clk.
6. rst pulsed mid-snooze (counter=150) → all outputs 0, state=0 next clk. Subsequent ticks cause no ring.
